// File: rtl/bus_pkg.sv
// Shared system-bus definitions: request/response tag layout, command
// and target-type codes, and the line-master state encoding.
package bus_pkg;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam logic [3:0] MEMORY = 4'h1;
    localparam logic [3:0] MMIO   = 4'h2;
    localparam logic [3:0] PORT   = 4'h3;
    localparam logic [3:0] IRQ    = 4'h4;

    localparam int RW_BIT   = 12;
    localparam int TYPE_MSB = 11;
    localparam int TYPE_LSB = 8;
    localparam int ID_MSB   = 7;
    localparam int ID_LSB   = 0;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        RDATA,
        RESP
    } bus_master_state_t;

endpackage

// File: rtl/line_beat_buffer.sv
// One cache line held as BEATS bus-width words: bulk load for writes,
// per-beat indexed write for read assembly, indexed read for serialisation.
module line_beat_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int BEATS      = 8,
    parameter int IDX_W      = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load,
    input  logic [BEATS*DATA_WIDTH-1:0] load_line,
    input  logic                        wr_en,
    input  logic [IDX_W-1:0]            wr_idx,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic [IDX_W-1:0]            rd_idx,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic [BEATS*DATA_WIDTH-1:0] line
);

    logic [DATA_WIDTH-1:0] mem [BEATS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BEATS; i++) begin
                mem[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < BEATS; i++) begin
                mem[i] <= load_line[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

    for (genvar g = 0; g < BEATS; g++) begin : g_line
        assign line[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
    end

endmodule

// File: rtl/bus_line_master.sv
// Requester-side bus master moving one cache line per transaction:
// address beat, then write-data beats out or read-data beats in.
module bus_line_master
    import bus_pkg::*;
#(
    parameter int         DATA_WIDTH = 64,
    parameter int         TAG_WIDTH  = 13,
    parameter int         LINE_BYTES = 64,
    parameter logic [7:0] CLIENT_ID  = 8'h00
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cl_req_valid,
    output logic                    cl_req_ready,
    input  logic                    cl_req_write,
    input  logic [DATA_WIDTH-1:0]   cl_req_addr,
    input  logic [LINE_BYTES*8-1:0] cl_req_wdata,
    output logic                    cl_resp_valid,
    input  logic                    cl_resp_ready,
    output logic [LINE_BYTES*8-1:0] cl_resp_rdata,
    output logic [DATA_WIDTH-1:0]   bus_req,
    output logic [TAG_WIDTH-1:0]    bus_reqtag,
    output logic                    bus_reqcyc,
    input  logic                    bus_reqack,
    input  logic [DATA_WIDTH-1:0]   bus_resp,
    input  logic [TAG_WIDTH-1:0]    bus_resptag,
    input  logic                    bus_respcyc,
    output logic                    bus_respack
);

    localparam int BEATS = LINE_BYTES * 8 / DATA_WIDTH;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF   = $clog2(LINE_BYTES);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    bus_master_state_t state, next_state;

    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [TAG_WIDTH-1:0]  req_tag;
    logic [DATA_WIDTH-1:0] beat_rd;
    logic                  resp_match;
    logic                  last_beat;
    logic                  buf_load;
    logic                  buf_wr;

    // Only beats tagged with our id belong to us; others are left for other masters.
    assign resp_match = bus_respcyc && (bus_resptag[ID_MSB:ID_LSB] == CLIENT_ID);
    assign last_beat  = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (cl_req_valid) begin
                        addr_q  <= {cl_req_addr[DATA_WIDTH-1:OFF], {OFF{1'b0}}};
                        write_q <= cl_req_write;
                    end
                end
                ADDR:    if (bus_reqack) cnt <= '0;
                WDATA:   if (bus_reqack) cnt <= cnt + CW'(1);
                RDATA:   if (resp_match) cnt <= cnt + CW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        req_tag                    = '0;
        req_tag[RW_BIT]            = write_q ? WRITE : READ;
        req_tag[TYPE_MSB:TYPE_LSB] = MEMORY;
        req_tag[ID_MSB:ID_LSB]     = CLIENT_ID;
    end

    always_comb begin
        next_state    = state;
        cl_req_ready  = 1'b0;
        cl_resp_valid = 1'b0;
        bus_reqcyc    = 1'b0;
        bus_respack   = 1'b0;
        buf_load      = 1'b0;
        buf_wr        = 1'b0;
        case (state)
            IDLE: begin
                cl_req_ready = 1'b1;
                if (cl_req_valid) begin
                    next_state = ADDR;
                    buf_load   = cl_req_write;
                end
            end
            ADDR: begin
                bus_reqcyc = 1'b1;
                if (bus_reqack) next_state = write_q ? WDATA : RDATA;
            end
            WDATA: begin
                bus_reqcyc = 1'b1;
                if (bus_reqack && last_beat) next_state = RESP;
            end
            RDATA: begin
                bus_respack = resp_match;
                buf_wr      = resp_match;
                if (resp_match && last_beat) next_state = RESP;
            end
            RESP: begin
                cl_resp_valid = 1'b1;
                if (cl_resp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Address and tag are driven only while a request beat is on the bus.
    always_comb begin
        bus_req    = '0;
        bus_reqtag = '0;
        case (state)
            ADDR: begin
                bus_req    = addr_q;
                bus_reqtag = req_tag;
            end
            WDATA: begin
                bus_req    = beat_rd;
                bus_reqtag = req_tag;
            end
            default: ;
        endcase
    end

    line_beat_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BEATS      (BEATS),
        .IDX_W      (CW)
    ) u_buffer (
        .clk        (clk),
        .reset      (reset),
        .load       (buf_load),
        .load_line  (cl_req_wdata),
        .wr_en      (buf_wr),
        .wr_idx     (cnt),
        .wr_data    (bus_resp),
        .rd_idx     (cnt),
        .rd_data    (beat_rd),
        .line       (cl_resp_rdata)
    );

endmodule

// File: tb/tb_bus_line_master.sv
// Self-checking bench for bus_line_master: scripted and randomised line
// reads/writes compared against a transaction-level model of the bus protocol.
module tb_bus_line_master;

    localparam int DW    = 64;
    localparam int TW    = 13;
    localparam int LB    = 64;
    localparam int BEATS = 8;

    typedef logic [DW-1:0] line_t [BEATS];
    typedef int stall_t [BEATS+1];

    logic            clk = 1'b0;
    logic            reset;
    logic            cl_req_valid;
    logic            cl_req_ready;
    logic            cl_req_write;
    logic [DW-1:0]   cl_req_addr;
    logic [LB*8-1:0] cl_req_wdata;
    logic            cl_resp_valid;
    logic            cl_resp_ready;
    logic [LB*8-1:0] cl_resp_rdata;
    logic [DW-1:0]   bus_req;
    logic [TW-1:0]   bus_reqtag;
    logic            bus_reqcyc;
    logic            bus_reqack;
    logic [DW-1:0]   bus_resp;
    logic [TW-1:0]   bus_resptag;
    logic            bus_respcyc;
    logic            bus_respack;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_line_master dut (
        .clk           (clk),
        .reset         (reset),
        .cl_req_valid  (cl_req_valid),
        .cl_req_ready  (cl_req_ready),
        .cl_req_write  (cl_req_write),
        .cl_req_addr   (cl_req_addr),
        .cl_req_wdata  (cl_req_wdata),
        .cl_resp_valid (cl_resp_valid),
        .cl_resp_ready (cl_resp_ready),
        .cl_resp_rdata (cl_resp_rdata),
        .bus_req       (bus_req),
        .bus_reqtag    (bus_reqtag),
        .bus_reqcyc    (bus_reqcyc),
        .bus_reqack    (bus_reqack),
        .bus_resp      (bus_resp),
        .bus_resptag   (bus_resptag),
        .bus_respcyc   (bus_respcyc),
        .bus_respack   (bus_respack)
    );

    // Reference rules: line-aligned address, tag = {read?1:0, MEMORY, id 0}.
    function automatic logic [DW-1:0] aligned(input logic [DW-1:0] a);
        return a & ~DW'(LB - 1);
    endfunction

    function automatic logic [TW-1:0] exp_tag(input logic is_write);
        return {~is_write, 4'h1, 8'h00};
    endfunction

    function automatic logic [LB*8-1:0] pack(input line_t l);
        logic [LB*8-1:0] p;
        for (int i = 0; i < BEATS; i++) p[i*DW +: DW] = l[i];
        return p;
    endfunction

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < BEATS; i++) l[i] = {$urandom, $urandom};
        return l;
    endfunction

    task automatic idle_inputs();
        cl_req_valid  = 1'b0;
        cl_req_write  = 1'b0;
        cl_req_addr   = '0;
        cl_req_wdata  = '0;
        cl_resp_ready = 1'b0;
        bus_reqack    = 1'b0;
        bus_resp      = '0;
        bus_resptag   = '0;
        bus_respcyc   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Full read: immediate address ack, one beat per cycle, optional foreign beat before slot foreign_pos, optional back-pressure.
    task automatic run_read(input logic [DW-1:0] addr, input line_t beats, input int foreign_pos,
                            input int bp_cycles, input string name);
        int cyc;
        int k;
        int guard;
        bit foreign_done;
        int exp_cyc;
        foreign_done = 0;
        @(negedge clk);
        checks++;
        if (cl_req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s req_ready: got %b expected 1", name, cl_req_ready);
        end
        cl_req_valid = 1'b1;
        cl_req_write = 1'b0;
        cl_req_addr  = addr;
        cl_req_wdata = pack(rand_line());
        @(posedge clk);
        @(negedge clk);
        cyc = 1;
        cl_req_valid = 1'b0;
        cl_req_addr  = {$urandom, $urandom};
        checks++;
        if (bus_reqcyc !== 1'b1 || bus_req !== aligned(addr) || bus_reqtag !== exp_tag(1'b0)) begin
            errors++;
            $display("[TB] FAIL %s addr_beat: got cyc=%b req=%h tag=%h expected cyc=1 req=%h tag=%h",
                     name, bus_reqcyc, bus_req, bus_reqtag, aligned(addr), exp_tag(1'b0));
        end
        bus_reqack = 1'b1;
        @(posedge clk);
        k = 0;
        guard = 0;
        while (k < BEATS && guard < 40) begin
            @(negedge clk);
            cyc++;
            guard++;
            bus_reqack  = 1'b0;
            bus_respcyc = 1'b1;
            if (k == foreign_pos && !foreign_done) begin
                foreign_done = 1;
                bus_resptag  = {1'b1, 4'h1, 8'h05};
                bus_resp     = {$urandom, $urandom};
                #1;
                checks++;
                if (bus_respack !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s foreign_ack: got %b expected 0", name, bus_respack);
                end
            end else begin
                bus_resptag = {1'b1, 4'h1, 8'h00};
                bus_resp    = beats[k];
                #1;
                checks++;
                if (bus_respack !== 1'b1 || bus_reqcyc !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s beat%0d_ack: got ack=%b reqcyc=%b expected ack=1 reqcyc=0",
                             name, k, bus_respack, bus_reqcyc);
                end
                k++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        cyc++;
        bus_respcyc = 1'b0;
        guard = 0;
        while (cl_resp_valid !== 1'b1 && guard < 20) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            guard++;
        end
        exp_cyc = 10 + ((foreign_pos >= 0 && foreign_pos < BEATS) ? 1 : 0);
        checks++;
        if (cl_resp_valid !== 1'b1 || cyc != exp_cyc) begin
            errors++;
            $display("[TB] FAIL %s latency: got valid=%b at cycle %0d expected valid=1 at cycle %0d",
                     name, cl_resp_valid, cyc, exp_cyc);
        end
        for (int i = 0; i < BEATS; i++) begin
            checks++;
            if (cl_resp_rdata[i*DW +: DW] !== beats[i]) begin
                errors++;
                $display("[TB] FAIL %s rdata[%0d]: got %h expected %h", name, i,
                         cl_resp_rdata[i*DW +: DW], beats[i]);
            end
        end
        if (bp_cycles > 0) begin
            cl_req_valid = 1'b1;
            cl_req_write = 1'b0;
            cl_req_addr  = {$urandom, $urandom};
        end
        for (int j = 0; j < bp_cycles; j++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (cl_resp_valid !== 1'b1 || cl_resp_rdata !== pack(beats) || cl_req_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s backpressure%0d: got valid=%b ready=%b data_ok=%b expected 1 0 1",
                         name, j, cl_resp_valid, cl_req_ready, cl_resp_rdata === pack(beats));
            end
        end
        cl_resp_ready = 1'b1;
        #1;
        checks++;
        if (cl_req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s ready_in_handshake: got %b expected 0", name, cl_req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        cl_resp_ready = 1'b0;
        cl_req_valid  = 1'b0;
        checks++;
        if (cl_req_ready !== 1'b1 || cl_resp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s back_to_idle: got ready=%b valid=%b expected 1 0",
                     name, cl_req_ready, cl_resp_valid);
        end
    endtask

    // Full write: stalls[k] cycles of withheld ack before beat k (0 = address beat).
    task automatic run_write(input logic [DW-1:0] addr, input line_t data, input stall_t stalls,
                             input string name);
        int cyc;
        int k;
        int stall;
        int guard;
        int total;
        logic ack;
        logic [DW-1:0] exp_beat;
        total = 0;
        for (int i = 0; i <= BEATS; i++) total += stalls[i];
        @(negedge clk);
        checks++;
        if (cl_req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s req_ready: got %b expected 1", name, cl_req_ready);
        end
        cl_req_valid = 1'b1;
        cl_req_write = 1'b1;
        cl_req_addr  = addr;
        cl_req_wdata = pack(data);
        @(posedge clk);
        @(negedge clk);
        cl_req_valid = 1'b0;
        cl_req_wdata = ~pack(data);
        cyc   = 1;
        k     = 0;
        stall = stalls[0];
        guard = 0;
        while (k <= BEATS && guard < 100) begin
            guard++;
            exp_beat    = (k == 0) ? aligned(addr) : data[k-1];
            bus_respcyc = 1'($urandom_range(0, 1));
            bus_resptag = {1'b1, 4'h1, 8'h00};
            #1;
            checks++;
            if (bus_reqcyc !== 1'b1 || bus_req !== exp_beat || bus_reqtag !== exp_tag(1'b1)
                || bus_respack !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s beat%0d: got cyc=%b req=%h tag=%h respack=%b expected 1 %h %h 0",
                         name, k, bus_reqcyc, bus_req, bus_reqtag, bus_respack, exp_beat, exp_tag(1'b1));
            end
            if (stall > 0) begin
                ack = 1'b0;
                stall--;
            end else begin
                ack = 1'b1;
            end
            bus_reqack = ack;
            @(posedge clk);
            if (ack) begin
                k++;
                if (k <= BEATS) stall = stalls[k];
            end
            @(negedge clk);
            cyc++;
            bus_reqack  = 1'b0;
            bus_respcyc = 1'b0;
        end
        checks++;
        if (cl_resp_valid !== 1'b1 || bus_reqcyc !== 1'b0 || cyc != 10 + total) begin
            errors++;
            $display("[TB] FAIL %s completion: got valid=%b reqcyc=%b cycle=%0d expected 1 0 cycle=%0d",
                     name, cl_resp_valid, bus_reqcyc, cyc, 10 + total);
        end
        cl_resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cl_resp_ready = 1'b0;
        checks++;
        if (cl_req_ready !== 1'b1 || cl_resp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s back_to_idle: got ready=%b valid=%b expected 1 0",
                     name, cl_req_ready, cl_resp_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (cl_req_ready !== 1'b1 || cl_resp_valid !== 1'b0 || bus_reqcyc !== 1'b0 ||
            bus_respack !== 1'b0 || bus_req !== '0 || bus_reqtag !== '0 || cl_resp_rdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values: got ready=%b valid=%b reqcyc=%b respack=%b req=%h tag=%h rdata_zero=%b",
                     cl_req_ready, cl_resp_valid, bus_reqcyc, bus_respack, bus_req, bus_reqtag,
                     cl_resp_rdata === '0);
        end
    endtask

    task automatic test_read_basic();
        line_t b;
        for (int i = 0; i < BEATS; i++) b[i] = DW'(64'h10 + i);
        run_read(64'h1234, b, -1, 0, "read_basic");
    endtask

    task automatic test_write_stall();
        line_t d;
        stall_t s;
        for (int i = 0; i < BEATS; i++) d[i] = DW'(64'hA0 + i);
        for (int i = 0; i <= BEATS; i++) s[i] = 0;
        s[0] = 3;
        s[5] = 3;
        run_write(64'h80, d, s, "write_stall");
    endtask

    task automatic test_foreign_tag();
        run_read({$urandom, $urandom}, rand_line(), 3, 0, "foreign_tag");
    endtask

    task automatic test_back_pressure();
        run_read({$urandom, $urandom}, rand_line(), -1, 5, "back_pressure");
    endtask

    task automatic test_reset_mid_read();
        line_t b;
        b = rand_line();
        @(negedge clk);
        cl_req_valid = 1'b1;
        cl_req_write = 1'b0;
        cl_req_addr  = {$urandom, $urandom};
        @(posedge clk);
        @(negedge clk);
        cl_req_valid = 1'b0;
        bus_reqack   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b1;
        bus_resptag = {1'b1, 4'h1, 8'h00};
        for (int i = 0; i < 4; i++) begin
            bus_resp = b[i];
            @(posedge clk);
            @(negedge clk);
        end
        bus_resp = b[4];
        reset    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus_reqcyc !== 1'b0 || bus_respack !== 1'b0 || cl_req_ready !== 1'b1 ||
            cl_resp_valid !== 1'b0 || cl_resp_rdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_read: got reqcyc=%b respack=%b ready=%b valid=%b rdata_zero=%b expected 0 0 1 0 1",
                     bus_reqcyc, bus_respack, cl_req_ready, cl_resp_valid, cl_resp_rdata === '0);
        end
        bus_respcyc = 1'b0;
        run_read({$urandom, $urandom}, rand_line(), -1, 0, "read_after_reset");
    endtask

    task automatic test_spurious_resp();
        logic [DW-1:0] a;
        a = {$urandom, $urandom};
        @(negedge clk);
        bus_respcyc = 1'b1;
        bus_resptag = {1'b1, 4'h1, 8'h00};
        #1;
        checks++;
        if (bus_respack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL spurious_idle_ack: got %b expected 0", bus_respack);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (cl_req_ready !== 1'b1 || bus_reqcyc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL spurious_idle_state: got ready=%b reqcyc=%b expected 1 0", cl_req_ready, bus_reqcyc);
        end
        cl_req_valid = 1'b1;
        cl_req_write = 1'b0;
        cl_req_addr  = a;
        @(posedge clk);
        @(negedge clk);
        cl_req_valid = 1'b0;
        #1;
        checks++;
        if (bus_respack !== 1'b0 || bus_reqcyc !== 1'b1) begin
            errors++;
            $display("[TB] FAIL spurious_addr_ack: got respack=%b reqcyc=%b expected 0 1", bus_respack, bus_reqcyc);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus_reqcyc !== 1'b1 || bus_req !== aligned(a) || bus_respack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL spurious_addr_state: got reqcyc=%b req=%h respack=%b expected 1 %h 0",
                     bus_reqcyc, bus_req, bus_respack, aligned(a));
        end
        do_reset();
    endtask

    task automatic test_random();
        stall_t s;
        for (int n = 0; n < 8; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= BEATS; i++) s[i] = int'($urandom_range(0, 2));
                run_write({$urandom, $urandom}, rand_line(), s, "random_write");
            end else begin
                run_read({$urandom, $urandom}, rand_line(),
                         ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, BEATS - 1)) : -1,
                         int'($urandom_range(0, 3)), "random_read");
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_read_basic();
        test_write_stall();
        test_foreign_tag();
        test_back_pressure();
        test_reset_mid_read();
        test_spurious_resp();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
